// File: rtl/seq_alu_exec.sv
// Multi-cycle EX-stage integer unit: single-cycle logic/arith ops, iterative 1-bit/cycle shifter.
// Define SEQ_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module seq_alu_exec #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1010;

  state_t          state, state_n;
  logic [XLEN-1:0] res_q, res_n;
  logic            zero_q, zero_n;
  logic            ill_q, ill_n;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            accept;
  logic [SHW-1:0]  shamt;

  assign shamt     = op_b[SHW-1:0];
  // Reset gates in_ready so nothing appears acceptable while rst_n is low.
  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
`ifdef SEQ_ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
`else
      // Zero-distance shifts finish here; nonzero ones go to the iterative path.
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifndef SEQ_ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} sk_t;

  logic [SHW-1:0]  cnt_q, cnt_n;
  sk_t             kind_q, kind_n;
  logic [XLEN-1:0] step;
  logic            is_shift;

  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);

  always_comb begin
    case (kind_q)
      SK_SLL:  step = {res_q[XLEN-2:0], 1'b0};
      SK_SRL:  step = {1'b0, res_q[XLEN-1:1]};
      default: step = {res_q[XLEN-1], res_q[XLEN-1:1]};
    endcase
  end
`endif

  always_comb begin
    state_n = state;
    res_n   = res_q;
    zero_n  = zero_q;
    ill_n   = ill_q;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
    cnt_n   = cnt_q;
    kind_n  = kind_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
`ifndef SEQ_ALU_BARREL_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            res_n   = op_a;
            cnt_n   = shamt;
            kind_n  = (alu_ctrl == OP_SLL) ? SK_SLL :
                      (alu_ctrl == OP_SRL) ? SK_SRL : SK_SRA;
            zero_n  = 1'b0;
            ill_n   = 1'b0;
            state_n = SHIFT;
          end else
`endif
          begin
            res_n   = alu_res;
            zero_n  = (alu_res == '0);
            ill_n   = alu_ill;
            state_n = DONE;
          end
        end
      end
`ifndef SEQ_ALU_BARREL_SHIFT_EN
      SHIFT: begin
        res_n = step;
        cnt_n = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          zero_n  = (step == '0);
          state_n = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      res_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
      cnt_q  <= '0;
      kind_q <= SK_SLL;
`endif
    end else begin
      state  <= state_n;
      res_q  <= res_n;
      zero_q <= zero_n;
      ill_q  <= ill_n;
`ifndef SEQ_ALU_BARREL_SHIFT_EN
      cnt_q  <= cnt_n;
      kind_q <= kind_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Directed self-checking bench for seq_alu_exec (XLEN=32), hand-computed vectors.
module tb_seq_alu_exec;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic stable;

  seq_alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int shift_lat(input int sh);
`ifdef SEQ_ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (sh == 0) ? 1 : 1 + sh;
`endif
  endfunction

  // Present one request, scramble inputs after acceptance, then wait (bounded) for out_valid.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      output int l);
    alu_ctrl = c; op_a = a; op_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; alu_ctrl = 4'hF; op_a = $urandom; op_b = $urandom;
    l = 1;
    while (!out_valid && l < 200) begin
      tick();
      l++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consume_out_valid", {31'b0, out_valid}, 32'd0);
    chk("consume_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero_ill", {30'b0, zero, illegal}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("post_rst_no_accept", {31'b0, out_valid}, 32'd0);

    send(4'b0010, 32'h7FFF_FFFF, 32'd1, lat);
    chk("add_lat", lat, 32'd1);
    chk("add_res", result, 32'h8000_0000);
    chk("add_zero", {31'b0, zero}, 32'd0);
    consume();

    send(4'b0110, 32'd5, 32'd5, lat);
    chk("sub_res", result, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    consume();

    send(4'b0100, 32'hFFFF_FFFF, 32'd1, lat);
    chk("slt_res", result, 32'd1);
    consume();

    send(4'b0101, 32'hFFFF_FFFF, 32'd1, lat);
    chk("sltu_res", result, 32'd0);
    chk("sltu_zero", {31'b0, zero}, 32'd1);
    consume();

    send(4'b0001, 32'h0000_F000, 32'h0000_000F, lat);
    chk("or_res", result, 32'h0000_F00F);
    consume();

    send(4'b1010, 32'h8000_0000, 32'd4, lat);
    chk("sra_lat", lat, shift_lat(4));
    chk("sra_res", result, 32'hF800_0000);
    consume();

    send(4'b1000, 32'h8000_0000, 32'd31, lat);
    chk("srl31_lat", lat, shift_lat(31));
    chk("srl31_res", result, 32'd1);
    chk("srl31_zero", {31'b0, zero}, 32'd0);
    consume();

    send(4'b0011, 32'd1, 32'd0, lat);
    chk("sll0_lat", lat, 32'd1);
    chk("sll0_res", result, 32'd1);
    consume();

    send(4'b0011, 32'd1, 32'h25, lat);
    chk("sll_hi_bits_lat", lat, shift_lat(5));
    chk("sll_hi_bits_res", result, 32'h20);
    consume();

    send(4'b1000, 32'h0000_0010, 32'd5, lat);
    chk("srl_to_zero_res", result, 32'd0);
    chk("srl_to_zero_zero", {31'b0, zero}, 32'd1);
    consume();

    // Backpressure: hold result while a second request waits upstream.
    send(4'b0111, 32'h0000_FFFF, 32'h00FF_00FF, lat);
    alu_ctrl = 4'b0010; op_a = 32'd3; op_b = 32'd4; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!out_valid || result !== 32'h00FF_FF00 || in_ready) stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    chk("bp_res", result, 32'h00FF_FF00);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_res", result, 32'd7);
    consume();

    send(4'b1111, 32'h1234, 32'h5678, lat);
    chk("ill_lat", lat, 32'd1);
    chk("ill_res", result, 32'd0);
    chk("ill_flags", {30'b0, zero, illegal}, 32'd3);
    consume();
    send(4'b0000, 32'hF0, 32'h3C, lat);
    chk("and_res", result, 32'h30);
    chk("and_clears_ill", {31'b0, illegal}, 32'd0);
    consume();

    // Reset during the fifth SHIFT cycle abandons the shift.
    alu_ctrl = 4'b1000; op_a = 32'hFFFF_FFFF; op_b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_res", result, 32'd0);
    stable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) stable = 1'b0;
      tick();
    end
    chk("midrst_no_out", {31'b0, stable}, 32'd1);
    send(4'b0111, 32'hF0F0_F0F0, 32'hFFFF_FFFF, lat);
    chk("post_midrst_lat", lat, 32'd1);
    chk("post_midrst_res", result, 32'h0F0F_0F0F);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
